// File: rtl/fp16_add_issue_if.sv
// Handshake bundle between the FP16 operand sequencer, the adder pipeline and the result consumer.
// slave = sequencer side; master = environment (upstream source, adder, downstream sink).
// Optional err_cnt exists only when FP16_ADD_ISSUE_ERRCNT_EN is defined.
interface fp16_add_issue_if;
    logic        in_valid;
    logic [15:0] in_data;
    logic        in_last;
    logic        in_ready;
    logic [15:0] add_data1;
    logic [15:0] add_data2;
    logic        add_valid;
    logic [15:0] add_result;
    logic        add_update;
    logic        out_valid;
    logic [15:0] out_data;
    logic        out_ready;
    logic        err_ovf;
`ifdef FP16_ADD_ISSUE_ERRCNT_EN
    logic [7:0]  err_cnt;
`endif

    modport slave (
        input  in_valid, in_data, in_last, add_result, add_update, out_ready,
        output in_ready, add_data1, add_data2, add_valid, out_valid, out_data, err_ovf
`ifdef FP16_ADD_ISSUE_ERRCNT_EN
        , output err_cnt
`endif
    );

    modport master (
        output in_valid, in_data, in_last, add_result, add_update, out_ready,
        input  in_ready, add_data1, add_data2, add_valid, out_valid, out_data, err_ovf
`ifdef FP16_ADD_ISSUE_ERRCNT_EN
        , input err_cnt
`endif
    );
endinterface

// File: rtl/fp16_add_issue.sv
// Pairs a stream of FP16 values into adder operands and buffers adder results in a DEPTH-entry FIFO.
// Latency: accept->add_valid 1 cycle, add_update->out_valid 1 cycle. Optional FP16_ADD_ISSUE_ERRCNT_EN adds err_cnt.
// Backpressure: in_ready drops when issue credits run out, so the adder can never overrun the FIFO.
module fp16_add_issue #(
    parameter int DEPTH = 4,
    parameter int CW    = 3
) (
    input  logic            clk,
    input  logic            rst,
    fp16_add_issue_if.slave bus
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic {IDLE, HOLD} state_t;

    state_t        state_q, state_d;
    logic [15:0]   opa_q, opa_d;
    logic [15:0]   d1_q, d1_d, d2_q, d2_d;
    logic          vld_q, vld_d;
    logic [CW-1:0] credit_q, credit_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] wr_q, rd_q;
    logic [15:0]   mem_q [DEPTH];
    logic          err_q;

    logic accept, issue, pop, push, full, ret;

    assign accept = bus.in_valid & bus.in_ready;
    assign issue  = accept & ((state_q == HOLD) | bus.in_last);
    assign full   = (cnt_q == CW'(DEPTH));
    assign pop    = (cnt_q != '0) & bus.out_ready;
    assign push   = bus.add_update & ~full;
    assign ret    = pop & (credit_q != CW'(DEPTH));

    assign bus.in_ready  = ~rst & (credit_q != '0);
    assign bus.add_data1 = d1_q;
    assign bus.add_data2 = d2_q;
    assign bus.add_valid = vld_q;
    assign bus.out_valid = (cnt_q != '0);
    assign bus.out_data  = mem_q[rd_q];
    assign bus.err_ovf   = err_q;

    always_comb begin
        state_d = state_q;
        opa_d   = opa_q;
        d1_d    = d1_q;
        d2_d    = d2_q;
        vld_d   = 1'b0;
        if (accept) begin
            case (state_q)
                IDLE: begin
                    if (bus.in_last) begin
                        vld_d = 1'b1;
                        d1_d  = bus.in_data;
                        d2_d  = 16'h0000;
                    end else begin
                        opa_d   = bus.in_data;
                        state_d = HOLD;
                    end
                end
                HOLD: begin
                    // in_last is irrelevant here: the pair completes either way
                    vld_d   = 1'b1;
                    d1_d    = opa_q;
                    d2_d    = bus.in_data;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        credit_d = credit_q;
        case ({issue, ret})
            2'b10:   credit_d = credit_q - CW'(1);
            2'b01:   credit_d = credit_q + CW'(1);
            default: credit_d = credit_q;
        endcase
        cnt_d = cnt_q;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            opa_q    <= '0;
            d1_q     <= '0;
            d2_q     <= '0;
            vld_q    <= 1'b0;
            credit_q <= CW'(DEPTH);
            cnt_q    <= '0;
            wr_q     <= '0;
            rd_q     <= '0;
            err_q    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            state_q  <= state_d;
            opa_q    <= opa_d;
            d1_q     <= d1_d;
            d2_q     <= d2_d;
            vld_q    <= vld_d;
            credit_q <= credit_d;
            cnt_q    <= cnt_d;
            if (push) begin
                mem_q[wr_q] <= bus.add_result;
                wr_q        <= wr_q + AW'(1);
            end
            if (pop) rd_q <= rd_q + AW'(1);
            if (bus.add_update & full) err_q <= 1'b1;
        end
    end

`ifdef FP16_ADD_ISSUE_ERRCNT_EN
    logic [7:0] errcnt_q;
    assign bus.err_cnt = errcnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            errcnt_q <= '0;
        end else if (push && bus.add_result == 16'hFFFF && errcnt_q != 8'hFF) begin
            errcnt_q <= errcnt_q + 8'd1;
        end
    end
`endif
endmodule

// File: tb/tb_fp16_add_issue.sv
// Bench for fp16_add_issue: a 7-cycle integer-valued FP16 adder stand-in plus a pairing/result reference model.
module tb_fp16_add_issue;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fp16_add_issue_if bus();
    fp16_add_issue #(.DEPTH(DEPTH), .CW(3)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_checks = 0;
    int n_fail   = 0;

    // FP16 helpers restricted to non-negative integer values, which is all the stimulus uses
    function automatic int dec(input logic [15:0] h);
        int e, mant;
        if (h[14:0] == 15'd0) return 0;
        e    = int'(h[14:10]);
        mant = 1024 + int'(h[9:0]);
        if (e >= 25) return mant << (e - 25);
        return mant >> (25 - e);
    endfunction

    function automatic logic [15:0] enc(input int n);
        int p, mant;
        if (n == 0) return 16'h0000;
        if (n > 65504) return 16'hFFFF;
        p = 0;
        while ((n >> (p + 1)) != 0) p++;
        if (p <= 10) mant = (n << (10 - p)) & 1023;
        else         mant = (n >> (p - 10)) & 1023;
        return {1'b0, 5'(p + 15), 10'(mant)};
    endfunction

    function automatic logic [15:0] fadd(input logic [15:0] a, input logic [15:0] b);
        return enc(dec(a) + dec(b));
    endfunction

    // Adder stand-in: fixed 7-cycle latency, in order
    logic [16:0] pipe [7];
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 7; i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= {bus.add_valid, fadd(bus.add_data1, bus.add_data2)};
            for (int i = 1; i < 7; i++) pipe[i] <= pipe[i-1];
        end
    end
    assign bus.add_update = pipe[6][16];
    assign bus.add_result = pipe[6][15:0];

    // Monitors: record every issued pair and every popped result
    logic [31:0] iss_q [$];
    logic [15:0] got_q [$];
    int          n_pulse = 0;
    always @(posedge clk) begin
        if (bus.add_valid) begin
            iss_q.push_back({bus.add_data1, bus.add_data2});
            n_pulse++;
        end
        if (bus.out_valid && bus.out_ready) got_q.push_back(bus.out_data);
    end

    logic [15:0] vals  [64];
    logic        lasts [64];
    int          n_vals;
    logic [31:0] exp_q [$];
    bit          drv_done;

    task automatic cyc(input int k);
        repeat (k) @(negedge clk);
    endtask

    task automatic send(input logic [15:0] d, input logic l);
        int n;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = l;
        n = 0;
        while (!bus.in_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (n >= 300) begin
            n_fail++;
            $display("FAIL send_timeout: in_ready stayed %0b for %0d cycles, required 1", bus.in_ready, n);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic run_driver(input int gapmax);
        for (int i = 0; i < n_vals; i++) begin
            repeat ($urandom_range(0, gapmax)) @(negedge clk);
            send(vals[i], lasts[i]);
        end
        drv_done = 1'b1;
    endtask

    // Reference pairing: consecutive values pair up, a lone in_last value pairs with +0
    task automatic build_model();
        logic        hold;
        logic [15:0] opa;
        exp_q.delete();
        hold = 1'b0;
        opa  = '0;
        for (int i = 0; i < n_vals; i++) begin
            if (hold) begin
                exp_q.push_back({opa, vals[i]});
                hold = 1'b0;
            end else if (lasts[i]) begin
                exp_q.push_back({vals[i], 16'h0000});
            end else begin
                opa  = vals[i];
                hold = 1'b1;
            end
        end
    endtask

    task automatic apply_reset();
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;
        cyc(2);
        rst = 1'b0;
        cyc(1);
    endtask

    task automatic test_reset();
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;
        cyc(2);
        n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %0b want 0", bus.in_ready); end
        n_checks++; if (bus.add_valid !== 1'b0) begin n_fail++; $display("FAIL reset_add_valid: got %0b want 0", bus.add_valid); end
        n_checks++; if ({bus.add_data1, bus.add_data2} !== 32'h0) begin n_fail++; $display("FAIL reset_add_data: got %h want 0", {bus.add_data1, bus.add_data2}); end
        n_checks++; if (bus.out_valid !== 1'b0 || bus.out_data !== 16'h0) begin n_fail++; $display("FAIL reset_out: got v=%0b d=%h want 0/0000", bus.out_valid, bus.out_data); end
        n_checks++; if (bus.err_ovf !== 1'b0) begin n_fail++; $display("FAIL reset_err_ovf: got %0b want 0", bus.err_ovf); end
        n_checks++; if (dut.credit_q !== 3'd4) begin n_fail++; $display("FAIL reset_credit: got %0d want 4", dut.credit_q); end
`ifdef FP16_ADD_ISSUE_ERRCNT_EN
        n_checks++; if (bus.err_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_err_cnt: got %0d want 0", bus.err_cnt); end
`endif
        rst = 1'b0;
        cyc(1);
        n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_in_ready: got %0b want 1", bus.in_ready); end
    endtask

    task automatic test_basic_pair();
        int g, k;
        g = got_q.size();
        send(16'h3C00, 1'b0);
        n_checks++; if (bus.add_valid !== 1'b0) begin n_fail++; $display("FAIL basic_first_no_issue: add_valid=%0b want 0", bus.add_valid); end
        send(16'h4000, 1'b0);
        n_checks++; if (bus.add_valid !== 1'b1 || bus.add_data1 !== 16'h3C00 || bus.add_data2 !== 16'h4000) begin
            n_fail++; $display("FAIL basic_issue: got v=%0b %h/%h want 1 3c00/4000", bus.add_valid, bus.add_data1, bus.add_data2);
        end
        k = 0;
        while (!bus.out_valid && k < 20) begin @(negedge clk); k++; end
        n_checks++; if (k != 8) begin n_fail++; $display("FAIL basic_latency: got %0d cycles want 8", k); end
        n_checks++; if (bus.out_data !== 16'h4200) begin n_fail++; $display("FAIL basic_result: got %h want 4200", bus.out_data); end
        bus.out_ready = 1'b1;
        cyc(1);
        bus.out_ready = 1'b0;
        n_checks++; if (got_q.size() != g + 1 || bus.out_valid !== 1'b0) begin
            n_fail++; $display("FAIL basic_pop: popped %0d out_valid=%0b want 1/0", got_q.size() - g, bus.out_valid);
        end
    endtask

    task automatic test_odd_tail();
        int g;
        g = got_q.size();
        send(16'h3C00, 1'b1);
        n_checks++; if (bus.add_valid !== 1'b1 || bus.add_data1 !== 16'h3C00 || bus.add_data2 !== 16'h0000) begin
            n_fail++; $display("FAIL tail_issue: got v=%0b %h/%h want 1 3c00/0000", bus.add_valid, bus.add_data1, bus.add_data2);
        end
        send(16'h4000, 1'b1);
        n_checks++; if (bus.add_valid !== 1'b1 || bus.add_data1 !== 16'h4000 || bus.add_data2 !== 16'h0000) begin
            n_fail++; $display("FAIL tail_stays_idle: got v=%0b %h/%h want 1 4000/0000", bus.add_valid, bus.add_data1, bus.add_data2);
        end
        bus.out_ready = 1'b1;
        cyc(12);
        bus.out_ready = 1'b0;
        n_checks++; if (got_q.size() != g + 2) begin n_fail++; $display("FAIL tail_count: got %0d want 2", got_q.size() - g); end
        else begin
            n_checks++; if (got_q[g] !== 16'h3C00 || got_q[g+1] !== 16'h4000) begin
                n_fail++; $display("FAIL tail_results: got %h %h want 3c00 4000", got_q[g], got_q[g+1]);
            end
        end
    endtask

    task automatic check_results(input string name, input int ib, input int gs);
        n_checks++;
        if (got_q.size() - gs != exp_q.size() || iss_q.size() - ib != exp_q.size()) begin
            n_fail++; $display("FAIL %s_count: issued %0d popped %0d want %0d", name, iss_q.size() - ib, got_q.size() - gs, exp_q.size());
        end else begin
            foreach (exp_q[i]) begin
                n_checks++;
                if (iss_q[ib+i] !== exp_q[i] || got_q[gs+i] !== fadd(exp_q[i][31:16], exp_q[i][15:0])) begin
                    n_fail++; $display("FAIL %s_item%0d: issued %h result %h want %h result %h", name, i, iss_q[ib+i], got_q[gs+i], exp_q[i], fadd(exp_q[i][31:16], exp_q[i][15:0]));
                end
            end
        end
    endtask

    task automatic test_credit_stall();
        int b, ib, gs, k;
        b = n_pulse; ib = iss_q.size(); gs = got_q.size();
        n_vals = 20;
        for (int i = 0; i < 20; i++) begin vals[i] = enc($urandom_range(1, 1000)); lasts[i] = 1'b0; end
        build_model();
        drv_done = 1'b0;
        fork run_driver(0); join_none
        cyc(40);
        n_checks++; if (n_pulse - b != 4) begin n_fail++; $display("FAIL stall_pulses: got %0d want 4", n_pulse - b); end
        n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready: got %0b want 0", bus.in_ready); end
        n_checks++; if (dut.cnt_q !== 3'd4) begin n_fail++; $display("FAIL stall_fifo_count: got %0d want 4", dut.cnt_q); end
        n_checks++; if (bus.err_ovf !== 1'b0) begin n_fail++; $display("FAIL stall_err_ovf: got %0b want 0", bus.err_ovf); end
        bus.out_ready = 1'b1;
        cyc(1);
        bus.out_ready = 1'b0;
        cyc(5);
        n_checks++; if (n_pulse - b != 5) begin n_fail++; $display("FAIL stall_one_credit: pulses %0d want 5", n_pulse - b); end
        bus.out_ready = 1'b1;
        k = 0;
        while (!drv_done && k < 500) begin @(negedge clk); k++; end
        cyc(15);
        bus.out_ready = 1'b0;
        n_checks++; if (!drv_done) begin n_fail++; $display("FAIL stall_drain: driver done=%0b want 1", drv_done); end
        check_results("stall", ib, gs);
    endtask

    task automatic test_simultaneous();
        int ib, gs, k;
        ib = iss_q.size(); gs = got_q.size();
        n_vals = 10;
        for (int i = 0; i < 10; i++) begin vals[i] = enc($urandom_range(0, 1023)); lasts[i] = 1'b0; end
        build_model();
        for (int i = 0; i < 6; i++) send(vals[i], 1'b0);
        cyc(12);
        n_checks++; if (dut.cnt_q !== 3'd3 || dut.credit_q !== 3'd1) begin
            n_fail++; $display("FAIL simul_setup: count %0d credit %0d want 3/1", dut.cnt_q, dut.credit_q);
        end
        send(vals[6], 1'b0);
        send(vals[7], 1'b0);
        k = 0;
        while (!bus.add_update && k < 20) begin @(negedge clk); k++; end
        bus.out_ready = 1'b1;
        cyc(1);
        bus.out_ready = 1'b0;
        n_checks++; if (dut.cnt_q !== 3'd3 || dut.credit_q !== 3'd1) begin
            n_fail++; $display("FAIL simul_push_pop: count %0d credit %0d want 3/1", dut.cnt_q, dut.credit_q);
        end
        send(vals[8], 1'b0);
        bus.in_valid  = 1'b1;
        bus.in_data   = vals[9];
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b1;
        cyc(1);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        n_checks++; if (dut.credit_q !== 3'd1 || dut.cnt_q !== 3'd2 || bus.add_valid !== 1'b1) begin
            n_fail++; $display("FAIL simul_issue_pop: credit %0d count %0d add_valid %0b want 1/2/1", dut.credit_q, dut.cnt_q, bus.add_valid);
        end
        bus.out_ready = 1'b1;
        cyc(12);
        bus.out_ready = 1'b0;
        check_results("simul", ib, gs);
    endtask

    task automatic test_overflow_code();
        apply_reset();
        send(16'h7BFF, 1'b0);
        send(16'h7BFF, 1'b0);
        cyc(9);
        n_checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 16'hFFFF) begin
            n_fail++; $display("FAIL ovf_code: got v=%0b d=%h want 1 ffff", bus.out_valid, bus.out_data);
        end
`ifdef FP16_ADD_ISSUE_ERRCNT_EN
        n_checks++; if (bus.err_cnt !== 8'd1) begin n_fail++; $display("FAIL ovf_err_cnt: got %0d want 1", bus.err_cnt); end
`endif
        n_checks++; if (bus.err_ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_err_ovf: got %0b want 0", bus.err_ovf); end
        bus.out_ready = 1'b1;
        cyc(1);
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 4; i++) send(enc(i + 5), 1'b0);
        cyc(10);
        send(16'h3C00, 1'b0);
        n_checks++; if (dut.cnt_q !== 3'd2) begin n_fail++; $display("FAIL rstmid_setup: count %0d want 2", dut.cnt_q); end
        #1 rst = 1'b1;
        #1;
        n_checks++; if (bus.out_valid !== 1'b0 || dut.credit_q !== 3'd4 || bus.in_ready !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_async: out_valid %0b credit %0d in_ready %0b want 0/4/0", bus.out_valid, dut.credit_q, bus.in_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        cyc(1);
        send(16'h4000, 1'b0);
        send(16'h4000, 1'b0);
        n_checks++; if (bus.add_valid !== 1'b1 || bus.add_data1 !== 16'h4000 || bus.add_data2 !== 16'h4000) begin
            n_fail++; $display("FAIL rstmid_pair: got v=%0b %h/%h want 1 4000/4000", bus.add_valid, bus.add_data1, bus.add_data2);
        end
        cyc(8);
        n_checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 16'h4400) begin
            n_fail++; $display("FAIL rstmid_result: got v=%0b d=%h want 1 4400", bus.out_valid, bus.out_data);
        end
        bus.out_ready = 1'b1;
        cyc(1);
        bus.out_ready = 1'b0;
    endtask

    task automatic test_random_stream();
        int ib, gs, k;
        ib = iss_q.size(); gs = got_q.size();
        n_vals = 48;
        for (int i = 0; i < 48; i++) begin
            vals[i]  = enc($urandom_range(0, 1023));
            lasts[i] = ($urandom_range(0, 3) == 0);
        end
        lasts[47] = 1'b1;
        build_model();
        drv_done = 1'b0;
        fork run_driver(2); join_none
        k = 0;
        while ((!drv_done || got_q.size() - gs < exp_q.size()) && k < 3000) begin
            @(negedge clk);
            bus.out_ready = 1'($urandom_range(0, 1));
            k++;
        end
        bus.out_ready = 1'b0;
        cyc(2);
        check_results("random", ib, gs);
        n_checks++; if (dut.credit_q !== 3'd4 || bus.out_valid !== 1'b0 || bus.err_ovf !== 1'b0) begin
            n_fail++; $display("FAIL random_final: credit %0d out_valid %0b err_ovf %0b want 4/0/0", dut.credit_q, bus.out_valid, bus.err_ovf);
        end
    endtask

    initial begin
        test_reset();
        test_basic_pair();
        test_odd_tail();
        test_credit_stall();
        test_simultaneous();
        test_overflow_code();
        test_reset_mid();
        test_random_stream();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/fp16_add_issue.md
Name: fp16_add_issue

Overview:
- Operand sequencer and result buffer wrapped around the FP16 adder pipeline (data1/data2/input_valid in; data_o/output_update out).
- Accepts a stream of single FP16 values, pairs consecutive values into adder operands, and issues one `input_valid` pulse per pair.
- Captures adder results into a small FIFO with a valid/ready output.
- Credit counter throttles issue, because the adder has no backpressure and must never overrun the result FIFO.

Parameters:
- DEPTH, 4, result FIFO entries and number of issue credits (power of 2, ≥2).
- CW, 3, credit/count width; must hold 0..DEPTH.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- in_valid  in  1  upstream value valid
- in_data  in  16  upstream FP16 value
- in_last  in  1  final value of a stream; an unpaired value is padded with +0
- in_ready  out  1  upstream handshake ready
- add_data1  out  16  to adder data1
- add_data2  out  16  to adder data2
- add_valid  out  1  to adder input_valid, one-cycle pulse per pair
- add_result  in  16  from adder data_o
- add_update  in  1  from adder output_update
- out_valid  out  1  result FIFO not empty
- out_data  out  16  result FIFO head
- out_ready  in  1  downstream accepts head
- err_ovf  out  1  sticky: add_update arrived while FIFO full

Behaviour:
- Reset: rst is asynchronous, active-high; clock is clk.
  - Reset values: credit=DEPTH; FIFO empty; state=IDLE.
  - All outputs 0: add_data1, add_data2, add_valid, out_valid, out_data, err_ovf.
  - in_ready is 0 during reset.
  - The adder shares rst, so no stale results exist after reset.
- Accept handshake: a value is accepted when in_valid & in_ready. in_ready = (credit != 0), combinational from registered credit.
- FSM:
  - IDLE, accept with in_last=0: opa <= in_data; go to HOLD.
  - IDLE, accept with in_last=1: issue pair (in_data, 16'h0000); stay IDLE.
  - HOLD, accept: issue pair (opa, in_data); go to IDLE. in_last is ignored in HOLD (pair completes anyway).
- Issue:
  - Registered. add_data1/add_data2 are loaded and add_valid=1 in the cycle after the accepting edge.
  - add_valid=0 otherwise; add_data* hold their last values.
  - Max rate is one pair per 2 accepts (or per 1 in_last accept in IDLE).
- Credits:
  - Consumed on the accept that issues a pair; the first operand in IDLE consumes none.
  - Returned on each FIFO pop (out_valid & out_ready).
  - Same-cycle consume and return leaves credit unchanged.
  - Credit never exceeds DEPTH and never underflows.
  - credit counts free FIFO slots minus pairs in flight in the adder.
- Result FIFO:
  - Push on add_update, writing add_result, including 16'hFFFF overflow codes.
  - Pop on out_valid & out_ready. out_data is the registered head, valid whenever out_valid=1.
  - Pointers wrap modulo DEPTH.
  - Push and pop in the same cycle: count unchanged, both pointers advance.
  - Push while full (only possible from a protocol violation): data dropped, err_ovf <= 1 until rst.
  - Pop while empty: ignored.
- Ordering: the adder is fixed-latency in-order, so results leave in issue order.
- Latency: last operand accept → add_valid is 1 cycle; add_valid → add_update is adder latency (7); add_update → out_valid is 1 cycle.

Optional Feature:
- Macro FP16_ADD_ISSUE_ERRCNT_EN.
- When defined:
  - Adds output err_cnt[7:0], a saturating count of pushed results equal to 16'hFFFF.
  - Reset to 0; saturates at 8'hFF.
- When undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Basic pair: in 0x3C00 then 0x4000, in_last=0 → one add_valid pulse with data1=0x3C00, data2=0x4000; out_data=0x4200 eight cycles later, out_valid=1.
- Odd tail: single 0x3C00 with in_last=1 in IDLE → add_data2=0x0000; result 0x3C00; FSM stays IDLE.
- Credit stall: DEPTH=4, out_ready=0, stream 20 values back-to-back → exactly 4 add_valid pulses; in_ready=0 after the 4th issue; FIFO count=4; err_ovf=0. Raising out_ready for one cycle → one credit returned and one more pair issued.
- Simultaneous events: FIFO at 3 entries, push and pop in the same cycle → count stays 3; credit unchanged when an issue coincides with a pop.
- Overflow code: 0x7BFF+0x7BFF → out_data=0xFFFF; with FP16_ADD_ISSUE_ERRCNT_EN, err_cnt=1.
- Reset mid-operation: assert rst while in HOLD with 2 FIFO entries → out_valid=0, credit=DEPTH, IDLE immediately (asynchronous). The next pair 0x4000+0x4000 yields 0x4400.
